horno_control_seq: RTL
======================

Name: horno_control_seq

Overview:
- Sequential, parametrised successor of the combinational oven control unit.
- Keeps the same sensor and actuator semantics: S door sensor, B emergency button, H heater, P door release, A alarm.
- Replaces the external timer input T with an internal, loadable countdown timer driven by a prescaler.
- Adds a cook-complete alarm pulse and a latched emergency state requiring explicit acknowledge; sits between front-panel inputs and actuator drivers.

Parameters:
- TIME_W, 8, width of cook-time value and remaining-time counter (time units).
- CYCLES_PER_TICK, 4, clock cycles per time unit (prescaler terminal count, >=1).
- ALARM_CYCLES, 8, clock cycles A stays high after normal completion (>=1).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- S  input  1  door sensor, 1 = door open.
- B  input  1  emergency button, 1 = pressed.
- start  input  1  start / acknowledge strobe, sampled each cycle.
- time_set  input  TIME_W  cook time in units, sampled only on accepted start.
- H  output  1  heater enable.
- P  output  1  door release, 1 = door unlocked.
- A  output  1  alarm.
- remaining  output  TIME_W  time units left.
- state_o  output  3  current state: IDLE=0, HEAT=1, DONE=2, EMERG=3, PAUSE=4.

Behaviour:
- Interface: one clock clk; rst synchronous, active-high.
- Reset: state IDLE, remaining=0, prescaler=0, alarm counter=0. Outputs H=0, P=1, A=0, state_o=0.
- Moore outputs, decoded from registered state only.
- Latency: input event sampled at edge N, outputs change after edge N (visible in cycle N+1).
- IDLE (H=0, P=1, A=0):
  - start=1, S=0, B=0, time_set!=0: remaining<=time_set, prescaler<=0, go HEAT.
  - start with time_set=0 or S=1 is ignored; stay IDLE.
- HEAT (H=1, P=0, A=0):
  - Prescaler counts 0..CYCLES_PER_TICK-1. On terminal count it wraps to 0 and remaining decrements.
  - Decrement from 1 to 0: go DONE, load alarm counter with ALARM_CYCLES-1.
  - Heater on for exactly time_set*CYCLES_PER_TICK cycles.
  - start while in HEAT is ignored (no reload).
- DONE (H=0, P=1, A=1):
  - Alarm counter decrements each cycle; at 0 go IDLE.
  - S=1 (door opened) ends the alarm early: go IDLE next edge.
- EMERG (H=0, P=1, A=1):
  - Entered from any state when B=1.
  - remaining<=0, prescaler<=0.
  - Exits to IDLE only when B=0 and start=1 in the same cycle.
  - start while B=1 is ignored.
- Door open in HEAT (S=1, B=0), feature off: abort to IDLE, remaining<=0.
- Priority for simultaneous events: rst > B > S > timer expiry > start.
  - B and expiry in same cycle: EMERG.
  - S and expiry in same cycle: IDLE without feature, PAUSE with feature.
- Reset mid-operation: any state returns to IDLE in one edge, counters cleared, H drops the following cycle.
- remaining never underflows; it holds 0 outside HEAT/PAUSE.
- state_o values 5-7 unreachable; treated as IDLE.

Optional Feature:
- Macro: HORNO_PAUSE_RESUME_EN.
- Defined:
  - S=1 in HEAT goes to PAUSE (H=0, P=1, A=0).
  - remaining and prescaler are held.
  - PAUSE resumes to HEAT on start=1 with S=0, prescaler continuing from its held value.
  - B=1 in PAUSE goes to EMERG.
- Undefined: PAUSE encoding unused; S=1 in HEAT aborts to IDLE as described in Behaviour.

Test Plan:
- Normal cook: rst, then start=1, time_set=3 (defaults) -> H=1 for exactly 12 cycles, remaining 3->2->1->0 every 4 cycles, then A=1, P=1 for 8 cycles, then IDLE with P=1, A=0.
- Zero time / door open: start with time_set=0 -> stays IDLE. start with time_set=5, S=1 -> stays IDLE, H never 1.
- Emergency: B=1 at cycle 5 of HEAT -> next cycle H=0, P=1, A=1, state_o=3, remaining=0. start with B=1 -> no exit. B=0 plus start=1 -> IDLE.
- Door abort (feature off): S=1 mid-HEAT with remaining=2 -> IDLE, remaining=0, H=0, P=1.
- Pause/resume (feature on): S=1 with remaining=2, prescaler=1 -> PAUSE, values held. S=0 plus start -> HEAT; total heater cycles equal 12.
- Simultaneous events and reset: B and expiry on same edge -> EMERG, not DONE. rst asserted in HEAT -> next cycle IDLE, all counters 0, H=0, P=1, A=0.

Source files
------------

// File: rtl/horno_control_seq.sv
// Sequential oven controller: door/emergency interlocks, prescaled cook timer,
// completion alarm and latched emergency. Optional pause/resume: HORNO_PAUSE_RESUME_EN.
module horno_control_seq #(
    parameter int TIME_W          = 8,
    parameter int CYCLES_PER_TICK = 4,
    parameter int ALARM_CYCLES    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S,
    input  logic              B,
    input  logic              start,
    input  logic [TIME_W-1:0] time_set,
    output logic              H,
    output logic              P,
    output logic              A,
    output logic [TIME_W-1:0] remaining,
    output logic [2:0]        state_o
);

    localparam int PRESC_W = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam int ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_TICK - 1);
    localparam logic [ALARM_W-1:0] ALARM_LOAD = ALARM_W'(ALARM_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HEAT  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_EMERG = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [TIME_W-1:0]  remaining_nxt;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nxt;
    logic [ALARM_W-1:0] alarm_cnt;
    logic [ALARM_W-1:0] alarm_nxt;

    logic start_ok;
    logic tick;
    logic last_unit;

    assign start_ok  = start && !S && (time_set != '0);
    assign tick      = (presc == PRESC_LAST);
    // Treat 0 like 1 so a corrupted counter can never wrap around.
    assign last_unit = (remaining <= TIME_W'(1));

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        presc_nxt     = presc;
        alarm_nxt     = alarm_cnt;

        if (B) begin
            state_nxt     = ST_EMERG;
            remaining_nxt = '0;
            presc_nxt     = '0;
            alarm_nxt     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    remaining_nxt = '0;
                    presc_nxt     = '0;
                    if (start_ok) begin
                        state_nxt     = ST_HEAT;
                        remaining_nxt = time_set;
                    end
                end

                ST_HEAT: begin
                    if (S) begin
`ifdef HORNO_PAUSE_RESUME_EN
                        state_nxt = ST_PAUSE;
`else
                        state_nxt     = ST_IDLE;
                        remaining_nxt = '0;
                        presc_nxt     = '0;
`endif
                    end else if (tick) begin
                        presc_nxt = '0;
                        if (last_unit) begin
                            state_nxt     = ST_DONE;
                            remaining_nxt = '0;
                            alarm_nxt     = ALARM_LOAD;
                        end else begin
                            remaining_nxt = remaining - TIME_W'(1);
                        end
                    end else begin
                        presc_nxt = presc + PRESC_W'(1);
                    end
                end

                ST_DONE: begin
                    remaining_nxt = '0;
                    if (S || (alarm_cnt == '0)) begin
                        state_nxt = ST_IDLE;
                        alarm_nxt = '0;
                    end else begin
                        alarm_nxt = alarm_cnt - ALARM_W'(1);
                    end
                end

                ST_EMERG: begin
                    remaining_nxt = '0;
                    presc_nxt     = '0;
                    if (start) begin
                        state_nxt = ST_IDLE;
                    end
                end

                ST_PAUSE: begin
`ifdef HORNO_PAUSE_RESUME_EN
                    // Counters stay frozen so the cook resumes exactly where it stopped.
                    if (start && !S) begin
                        state_nxt = ST_HEAT;
                    end
`else
                    state_nxt     = ST_IDLE;
                    remaining_nxt = '0;
                    presc_nxt     = '0;
                    alarm_nxt     = '0;
`endif
                end

                default: begin
                    state_nxt     = ST_IDLE;
                    remaining_nxt = '0;
                    presc_nxt     = '0;
                    alarm_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            presc     <= '0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            presc     <= presc_nxt;
            alarm_cnt <= alarm_nxt;
        end
    end

    // Moore outputs; unused encodings fall through to the IDLE output pattern.
    assign H       = (state == ST_HEAT);
    assign P       = (state != ST_HEAT);
    assign A       = (state == ST_DONE) || (state == ST_EMERG);
    assign state_o = state;

endmodule
